// File: rtl/neuron_operand_loader_if.sv
// neuron_operand_loader_if
//   Groups the beat stream coming into the loader and the vector bus going out
//   to the neuron core.
//   Ports carried:
//     stream : in_valid, in_ready, in_w, in_x, in_last, in_bias
//     neuron : w[N-1:0], x[N-1:0], bias, start, done
//     status : len_err, occupancy
//   Modports:
//     slave  - the loader itself (takes the stream, drives the neuron bus)
//     master - the environment (beat producer plus neuron core)
interface neuron_operand_loader_if #(
  parameter int N     = 8,
  parameter int width = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_w;
  logic [width-1:0] in_x;
  logic             in_last;
  logic [width-1:0] in_bias;
  logic [width-1:0] w [N-1:0];
  logic [width-1:0] x [N-1:0];
  logic [width-1:0] bias;
  logic             start;
  logic             done;
  logic             len_err;
  logic [1:0]       occupancy;

  modport slave (
    input  in_valid, in_w, in_x, in_last, in_bias, done,
    output in_ready, w, x, bias, start, len_err, occupancy
  );

  modport master (
    output in_valid, in_w, in_x, in_last, in_bias, done,
    input  in_ready, w, x, bias, start, len_err, occupancy
  );
endinterface

// File: rtl/neuron_operand_loader.sv
// neuron_operand_loader
//   Assembles a serial stream of (weight, activation) beats into N-element
//   parallel vectors plus a bias, and hands each finished vector to the neuron
//   core with a one-cycle start pulse. Two ping-pong banks let the next vector
//   load while the neuron works on the current one.
//   Ports:
//     clk   - single clock, rising edge
//     reset - synchronous, active-high, clears all state and bank contents
//     bus   - neuron_operand_loader_if.slave (stream in, vector bus out,
//             len_err pulse, occupancy count)
module neuron_operand_loader #(
  parameter int N     = 8,
  parameter int width = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  neuron_operand_loader_if.slave  bus
);

  localparam int              IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_BUSY  = 2'd2
  } bank_state_e;

  typedef enum logic {
    ISSUE_IDLE = 1'b0,
    ISSUE_WAIT = 1'b1
  } issue_state_e;

  logic [width-1:0] w_mem_q    [2][N];
  logic [width-1:0] w_mem_d    [2][N];
  logic [width-1:0] x_mem_q    [2][N];
  logic [width-1:0] x_mem_d    [2][N];
  logic [width-1:0] bias_mem_q [2];
  logic [width-1:0] bias_mem_d [2];

  bank_state_e      bank_q [2];
  bank_state_e      bank_d [2];
  issue_state_e     issue_q, issue_d;

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_q, start_d;
  logic             len_err_q, len_err_d;

  logic             in_ready;
  logic             accept;
  logic             close;

  // The fill side may only write into an EMPTY bank; a vector closes on an
  // explicit last beat or when the final element slot has been written.
  always_comb begin
    in_ready = (bank_q[wr_sel_q] == BANK_EMPTY);
    accept   = bus.in_valid & in_ready;
    close    = accept & (bus.in_last | (idx_q == LAST_IDX));
  end

  // Fill datapath: write the current element, and on close capture the bias,
  // clear the unused upper elements of a short vector so stale data from an
  // earlier vector never reaches the neuron, then move to the other bank.
  always_comb begin
    w_mem_d    = w_mem_q;
    x_mem_d    = x_mem_q;
    bias_mem_d = bias_mem_q;
    idx_d      = idx_q;
    wr_sel_d   = wr_sel_q;
    len_err_d  = 1'b0;
    if (accept) begin
      w_mem_d[wr_sel_q][idx_q] = bus.in_w;
      x_mem_d[wr_sel_q][idx_q] = bus.in_x;
      if (close) begin
        bias_mem_d[wr_sel_q] = bus.in_bias;
        for (int i = 0; i < N; i++) begin
          if (IDX_W'(i) > idx_q) begin
            w_mem_d[wr_sel_q][i] = '0;
            x_mem_d[wr_sel_q][i] = '0;
          end
        end
        wr_sel_d  = ~wr_sel_q;
        idx_d     = '0;
        // Closing without in_last can only happen on the final slot.
        len_err_d = ~bus.in_last;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Issue FSM plus bank bookkeeping. The issue side only touches the rd_sel
  // bank while it is FULL or BUSY, and the fill side only closes an EMPTY
  // bank, so both updates can land in the same cycle without colliding.
  always_comb begin
    bank_d   = bank_q;
    issue_d  = issue_q;
    rd_sel_d = rd_sel_q;
    start_d  = 1'b0;
    case (issue_q)
      ISSUE_IDLE: begin
        if (bank_q[rd_sel_q] == BANK_FULL) begin
          start_d          = 1'b1;
          bank_d[rd_sel_q] = BANK_BUSY;
          issue_d          = ISSUE_WAIT;
        end
      end
      ISSUE_WAIT: begin
        if (bus.done) begin
          bank_d[rd_sel_q] = BANK_EMPTY;
          rd_sel_d         = ~rd_sel_q;
          issue_d          = ISSUE_IDLE;
        end
      end
    endcase
    if (close) begin
      bank_d[wr_sel_q] = BANK_FULL;
    end
  end

  // State register with synchronous reset; reset also wipes the banks so the
  // neuron bus reads zero and any half-loaded vector is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          w_mem_q[b][i] <= '0;
          x_mem_q[b][i] <= '0;
        end
        bias_mem_q[b] <= '0;
        bank_q[b]     <= BANK_EMPTY;
      end
      issue_q   <= ISSUE_IDLE;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      idx_q     <= '0;
      start_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      w_mem_q    <= w_mem_d;
      x_mem_q    <= x_mem_d;
      bias_mem_q <= bias_mem_d;
      bank_q     <= bank_d;
      issue_q    <= issue_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      idx_q      <= idx_d;
      start_q    <= start_d;
      len_err_q  <= len_err_d;
    end
  end

  // The neuron always sees the rd_sel bank; it stays put while the vector is
  // in flight because rd_sel only moves on done.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.w[i] = w_mem_q[rd_sel_q][i];
      bus.x[i] = x_mem_q[rd_sel_q][i];
    end
    bus.bias      = bias_mem_q[rd_sel_q];
    bus.in_ready  = in_ready;
    bus.start     = start_q;
    bus.len_err   = len_err_q;
    bus.occupancy = 2'(bank_q[0] != BANK_EMPTY) + 2'(bank_q[1] != BANK_EMPTY);
  end

endmodule

// File: tb/tb_neuron_operand_loader.sv
// tb_neuron_operand_loader
//   Drives neuron_operand_loader through a table of single-vector beats, a set
//   of hand-built multi-cycle scenarios and a long randomized run. A queue-based
//   model of outstanding vectors predicts in_ready, occupancy, start, len_err
//   and the vector contents every cycle.
module tb_neuron_operand_loader;

  localparam int N  = 8;
  localparam int WD = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  neuron_operand_loader_if #(.N(N), .width(WD)) bus ();

  neuron_operand_loader #(.N(N), .width(WD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vec_count  = 0;
  int miscompares = 0;

  // Reference: every closed vector waits in a queue until the neuron has
  // consumed it; the head is the one being issued.
  typedef struct packed {
    logic [N-1:0][WD-1:0] w;
    logic [N-1:0][WD-1:0] x;
    logic [WD-1:0]        b;
  } vec_t;

  vec_t m_q[$];
  vec_t m_part;
  int   m_cnt;
  bit   m_flight;
  bit   m_start;
  bit   m_lerr;

  typedef struct {
    logic          v;
    logic [WD-1:0] w;
    logic [WD-1:0] x;
    logic          last;
    logic [WD-1:0] b;
    logic          done;
    logic          e_ready;
    logic          e_start;
    logic          e_lerr;
    logic [1:0]    e_occ;
  } row_t;

  row_t tbl [10];

  function automatic row_t mkRow(logic v, logic [WD-1:0] w, logic [WD-1:0] x,
                                 logic last, logic [WD-1:0] b, logic done,
                                 logic e_ready, logic e_start, logic e_lerr,
                                 logic [1:0] e_occ);
    row_t r;
    r.v = v; r.w = w; r.x = x; r.last = last; r.b = b; r.done = done;
    r.e_ready = e_ready; r.e_start = e_start; r.e_lerr = e_lerr; r.e_occ = e_occ;
    return r;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model over one clock edge using the inputs present at it.
  task automatic modelStep();
    int sz;
    bit rdy;
    if (reset) begin
      m_q.delete();
      m_part   = '0;
      m_cnt    = 0;
      m_flight = 0;
      m_start  = 0;
      m_lerr   = 0;
      return;
    end
    sz      = m_q.size();
    rdy     = (sz < 2);
    m_start = 0;
    m_lerr  = 0;
    if (!m_flight && sz > 0) begin
      m_start  = 1;
      m_flight = 1;
    end else if (m_flight && bus.done) begin
      void'(m_q.pop_front());
      m_flight = 0;
    end
    if (bus.in_valid && rdy) begin
      m_part.w[m_cnt] = bus.in_w;
      m_part.x[m_cnt] = bus.in_x;
      m_cnt++;
      if (bus.in_last || m_cnt == N) begin
        m_lerr   = !bus.in_last;
        m_part.b = bus.in_bias;
        m_q.push_back(m_part);
        m_part = '0;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
    checkOutput("occupancy", 32'(bus.occupancy), 32'(m_q.size()));
    checkOutput("start", 32'(bus.start), 32'(m_start));
    checkOutput("len_err", 32'(bus.len_err), 32'(m_lerr));
    if (m_flight) begin
      for (int i = 0; i < N; i++) begin
        checkOutput($sformatf("w[%0d]", i), 32'(bus.w[i]), 32'(m_q[0].w[i]));
        checkOutput($sformatf("x[%0d]", i), 32'(bus.x[i]), 32'(m_q[0].x[i]));
      end
      checkOutput("bias", 32'(bus.bias), 32'(m_q[0].b));
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(logic v, logic [WD-1:0] w, logic [WD-1:0] x,
                               logic last, logic [WD-1:0] b, logic done);
    bus.in_valid = v;
    bus.in_w     = w;
    bus.in_x     = x;
    bus.in_last  = last;
    bus.in_bias  = b;
    bus.done     = done;
  endtask

  task automatic idle(int n);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    repeat (n) cycle();
  endtask

  task automatic pulseDone();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    cycle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Hold a beat until the loader accepts it, bounded.
  task automatic sendBeat(logic [WD-1:0] w, logic [WD-1:0] x, logic last,
                          logic [WD-1:0] b);
    bit acc = 0;
    applyStimulus(1'b1, w, x, last, b, 1'b0);
    for (int k = 0; k < 200; k++) begin
      acc = bus.in_ready;
      cycle();
      if (acc) break;
    end
    if (!acc) checkOutput("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    cycle();
    reset = 1'b0;
  endtask

  task automatic checkZeroBus(string tag);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "_occupancy"}, 32'(bus.occupancy), 32'd0);
    checkOutput({tag, "_start"}, 32'(bus.start), 32'd0);
    checkOutput({tag, "_len_err"}, 32'(bus.len_err), 32'd0);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s_w[%0d]", tag, i), 32'(bus.w[i]), 32'd0);
      checkOutput($sformatf("%s_x[%0d]", tag, i), 32'(bus.x[i]), 32'd0);
    end
    checkOutput({tag, "_bias"}, 32'(bus.bias), 32'd0);
  endtask

  initial begin
    // Full vector: beats w=1..8, x=2, bias=3; start two cycles after beat 8.
    for (int r = 0; r < 8; r++) begin
      tbl[r] = mkRow(1'b1, WD'(r + 1), 8'd2, (r == 7), 8'd3, 1'b0,
                     1'b1, 1'b0, 1'b0, (r == 7) ? 2'd1 : 2'd0);
    end
    tbl[8] = mkRow(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
    tbl[9] = mkRow(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);

    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    doReset();
    checkZeroBus("reset");

    for (int r = 0; r < 10; r++) begin
      applyStimulus(tbl[r].v, tbl[r].w, tbl[r].x, tbl[r].last, tbl[r].b, tbl[r].done);
      cycle();
      checkOutput($sformatf("tbl%0d_in_ready", r), 32'(bus.in_ready), 32'(tbl[r].e_ready));
      checkOutput($sformatf("tbl%0d_start", r), 32'(bus.start), 32'(tbl[r].e_start));
      checkOutput($sformatf("tbl%0d_len_err", r), 32'(bus.len_err), 32'(tbl[r].e_lerr));
      checkOutput($sformatf("tbl%0d_occupancy", r), 32'(bus.occupancy), 32'(tbl[r].e_occ));
    end
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("full_w[%0d]", i), 32'(bus.w[i]), 32'(i + 1));
      checkOutput($sformatf("full_x[%0d]", i), 32'(bus.x[i]), 32'd2);
    end
    checkOutput("full_bias", 32'(bus.bias), 32'd3);
    pulseDone();
    checkOutput("full_done_occupancy", 32'(bus.occupancy), 32'd0);

    // Length error into bank 1, then a short vector into bank 0 (which still
    // holds 1..8) starting on the very next beat.
    for (int i = 0; i < N; i++) sendBeat(WD'(10 + i), 8'd3, 1'b0, 8'd9);
    checkOutput("lerr_pulse", 32'(bus.len_err), 32'd1);
    sendBeat(8'd5, 8'd1, 1'b0, 8'd0);
    checkOutput("lerr_pulse_once", 32'(bus.len_err), 32'd0);
    checkOutput("lerr_start", 32'(bus.start), 32'd1);
    checkOutput("lerr_w0", 32'(bus.w[0]), 32'd10);
    checkOutput("lerr_w7", 32'(bus.w[7]), 32'd17);
    checkOutput("lerr_bias", 32'(bus.bias), 32'd9);
    sendBeat(8'd6, 8'd1, 1'b0, 8'd0);
    sendBeat(8'd7, 8'd1, 1'b1, 8'd4);
    checkOutput("short_both_occupancy", 32'(bus.occupancy), 32'd2);
    checkOutput("short_both_in_ready", 32'(bus.in_ready), 32'd0);
    pulseDone();
    checkOutput("short_freed_in_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    checkOutput("short_start", 32'(bus.start), 32'd1);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("short_w[%0d]", i), 32'(bus.w[i]), (i < 3) ? 32'(5 + i) : 32'd0);
      checkOutput($sformatf("short_x[%0d]", i), 32'(bus.x[i]), (i < 3) ? 32'd1 : 32'd0);
    end
    checkOutput("short_bias", 32'(bus.bias), 32'd4);
    pulseDone();
    idle(2);

    // Ping-pong with done withheld: third vector waits for a free bank.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        sendBeat(WD'(16 * k + i), WD'(k + 1), (i == N - 1), WD'(40 + k));
    checkOutput("pp_full_occupancy", 32'(bus.occupancy), 32'd2);
    checkOutput("pp_full_in_ready", 32'(bus.in_ready), 32'd0);
    idle(3);
    checkOutput("pp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    pulseDone();
    checkOutput("pp_done1_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("pp_done1_start", 32'(bus.start), 32'd0);
    sendBeat(8'd32, 8'd3, 1'b0, 8'd42);
    checkOutput("pp_done2_start", 32'(bus.start), 32'd1);
    checkOutput("pp_v2_w0", 32'(bus.w[0]), 32'd16);
    checkOutput("pp_v2_bias", 32'(bus.bias), 32'd41);
    for (int i = 1; i < N; i++) sendBeat(WD'(32 + i), 8'd3, (i == N - 1), 8'd42);
    idle(2);
    pulseDone();
    idle(3);

    // Mid-operation reset: third vector is in WAIT, new vector on beat 4.
    for (int i = 0; i < 3; i++) sendBeat(WD'(60 + i), 8'd7, 1'b0, 8'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 8'd63, 8'd7, 1'b0, 8'd0, 1'b0);
    cycle();
    reset = 1'b0;
    checkZeroBus("midrst");
    idle(3);
    checkOutput("midrst_no_start", 32'(bus.start), 32'd0);
    for (int i = 0; i < N; i++) sendBeat(WD'(100 + i), WD'(200 - i), (i == N - 1), 8'd77);
    idle(3);
    pulseDone();
    idle(2);

    // Simultaneous: done for bank 0 in the cycle bank 1's closing beat lands.
    doReset();
    for (int i = 0; i < N; i++) sendBeat(WD'(i), 8'd9, (i == N - 1), 8'd1);
    idle(3);
    for (int i = 0; i < N - 1; i++) sendBeat(WD'(120 + i), 8'd8, 1'b0, 8'd0);
    checkOutput("sim_pre_in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 8'd127, 8'd8, 1'b1, 8'd55, 1'b1);
    cycle();
    checkOutput("sim_occupancy", 32'(bus.occupancy), 32'd1);
    checkOutput("sim_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("sim_start_early", 32'(bus.start), 32'd0);
    idle(1);
    checkOutput("sim_start", 32'(bus.start), 32'd1);
    checkOutput("sim_w0", 32'(bus.w[0]), 32'd120);
    checkOutput("sim_bias", 32'(bus.bias), 32'd55);
    pulseDone();
    idle(2);

    // Randomized run against the model, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus(($urandom_range(0, 9) < 7), WD'($urandom), WD'($urandom),
                    ($urandom_range(0, 5) == 0), WD'($urandom),
                    ($urandom_range(0, 3) == 0));
      cycle();
    end
    reset = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/neuron_operand_loader.md
# neuron_operand_loader

- Upstream feeder for the MLP neuron core.
- Accepts a serial stream of (weight, activation) pairs over a valid/ready handshake and assembles them into N-element parallel `w`/`x` vectors plus a bias.
- Hands each vector to the neuron with a one-cycle `start` pulse, then holds the vector stable until the neuron's `out_valid` returns.
- Two ping-pong banks let the next vector load while the neuron computes the current one.

## Interface

Parameters:
- N, 8, elements per vector (2..32)
- width, 8, bit width of each weight, activation and bias word

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  the current input beat is valid
- in_ready  out  1  loader can accept a beat this cycle
- in_w  in  width  weight for the current element
- in_x  in  width  activation for the current element
- in_last  in  1  the current beat is the final element of the vector
- in_bias  in  width  bias, sampled only on the beat that closes the vector
- w  out  width x N (unpacked [N-1:0])  weight vector to the neuron
- x  out  width x N (unpacked [N-1:0])  activation vector to the neuron
- bias  out  width  bias to the neuron
- start  out  1  one-cycle pulse: the vector on w/x/bias is ready
- done  in  1  neuron `out_valid`: the issued vector has been consumed
- len_err  out  1  one-cycle pulse: the Nth beat arrived without `in_last`
- occupancy  out  2  number of banks currently FULL or BUSY (0..2)

## Operation

**Banks**
- Two banks, 0 and 1. Each bank holds N w-words, N x-words and one bias word.
- Each bank has a state: EMPTY, FULL or BUSY.
- `wr_sel` selects the bank being filled; `rd_sel` selects the bank being issued.

**Fill side**
- A beat is accepted when `in_valid & in_ready`.
- `in_ready` = (state[wr_sel] == EMPTY), decoded from registered state.
- The element index `idx` counts 0..N-1. Each accepted beat writes `in_w`/`in_x` to bank[wr_sel][idx].
- The vector closes on the accepted beat where `in_last` is set or `idx == N-1`.
- On close:
  - `in_bias` is written to the bank.
  - If the vector is short (`in_last` at idx = k < N-1), elements k+1..N-1 of w and x are zeroed in the same cycle.
  - The bank becomes FULL, `wr_sel` toggles and `idx` returns to 0.
- If the beat at idx = N-1 lacks `in_last`:
  - The vector still closes normally.
  - `len_err` pulses in the following cycle.
  - The next beat starts a new vector.

**Issue FSM (states IDLE, WAIT)**
- IDLE: if state[rd_sel] == FULL, register `start` = 1, set that bank BUSY, and go to WAIT.
- WAIT: `start` = 0. On `done`, set bank[rd_sel] EMPTY, toggle `rd_sel`, and go to IDLE.
- `done` received in IDLE is ignored.

**Output muxing**
- `w`, `x` and `bias` are a combinational mux of bank[rd_sel].
- They are stable from the `start` cycle until the cycle after `done`.

**Concurrency**
- Fill and issue are independent. Closing a vector into one bank while `done` frees the other bank in the same cycle updates both bank states.
- `occupancy` counts banks not EMPTY.

**Reset**
- Takes effect on the first clock edge with `reset` high, including mid-vector or mid-WAIT.
- A partially filled vector is discarded.
- The neuron core is expected to be reset on the same signal.

## Timing

Reset values:
- `in_ready` = 1, `start` = 0, `len_err` = 0, `occupancy` = 0.
- All bank contents are 0, so `w`/`x`/`bias` read 0.
- `wr_sel` = `rd_sel` = 0, `idx` = 0, FSM = IDLE.

Latencies:
- Closing beat accepted in cycle t → bank FULL at t+1 → `start` high in cycle t+2.
- `done` in cycle d → FSM IDLE and bank EMPTY at d+1 → earliest next `start` at d+2 (if the other bank is FULL).
- A bank freed at d+1 makes `in_ready` 1 in cycle d+1 when it is `wr_sel`.

Throughput and backpressure:
- Streaming sustains one beat per cycle while a bank is EMPTY.
- With both banks non-EMPTY, `in_ready` = 0 and no beat is accepted. Inputs are don't-care while `in_ready` = 0.
- `start` is never high on two consecutive cycles.
- At most one bank is BUSY at any time.

## Test plan

- **Full vector.** Reset, then 8 beats w=1..8, x=2, `in_last` on beat 8, bias=3.
  - `start` pulses exactly 2 cycles after beat 8.
  - w = {1..8}, x = all 2, bias = 3; `occupancy` = 1.
- **Short vector.** 3 beats w=5,6,7, x=1, `in_last` on beat 3.
  - w = {5,6,7,0,0,0,0,0}, x = {1,1,1,0,0,0,0,0}.
  - Zeros in the upper elements persist even if the bank previously held data.
- **Length error.** 8 beats with no `in_last`.
  - `len_err` pulses once, the cycle after beat 8.
  - The vector issues normally; the 9th beat lands at idx 0 of the next bank.
- **Ping-pong and backpressure.** Stream 3 full vectors back-to-back with `done` withheld.
  - `in_ready` falls after the 2nd vector closes; `occupancy` = 2.
  - Assert `done` once: the 2nd vector issues at done+2, `in_ready` rises at done+1, and the 3rd vector loads.
- **Mid-operation reset.** Assert `reset` during beat 4 of a vector and while in WAIT.
  - Next cycle: `in_ready` = 1, `occupancy` = 0, w/x/bias = 0, no `start`.
  - A fresh vector then issues correctly.
- **Simultaneous events.** `done` for bank 0 in the same cycle the closing beat of bank 1's vector is accepted.
  - Bank 0 becomes EMPTY and bank 1 becomes FULL in that same update.
  - `start` for bank 1 occurs 2 cycles later.
